// File: rtl/spi_master_ctrl_if.sv
// Host handshake plus SPI pin bundle for spi_master_ctrl.
// The master modport is the controller's view; the slave modport is the host/slave side.
interface spi_master_ctrl_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [N-1:0] rx_data;
  logic         load;
  logic         sclk;
  logic         MOSI;
  logic         MISO;

  modport master (
    input  start, tx_data, MISO,
    output busy, done, rx_data, load, sclk, MOSI
  );

  modport slave (
    output start, tx_data, MISO,
    input  busy, done, rx_data, load, sclk, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: load strobe, then N bits MSB-first, DIV clk cycles per sclk half-period.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from MOSI instead of MISO.
module spi_master_ctrl #(
  parameter int N   = 16,
  parameter int DIV = 4
) (
  input  logic               clk,
  input  logic               clrn,
  spi_master_ctrl_if.master  bus
);

  localparam int              CW        = $clog2(N + 1);
  localparam logic [7:0]      HALF_LAST = 8'(DIV - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(N);

  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("spi_master_ctrl: DIV must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    half_q, half_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [N-1:0]  tx_sr_q, tx_sr_d;
  logic [N-1:0]  rx_sr_q, rx_sr_d;
  logic [N-1:0]  rx_data_q, rx_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_q, load_d;
  logic          sclk_q, sclk_d;
  logic          rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = tx_sr_q[N-1];
`else
  assign rx_bit = bus.MISO;
`endif

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          tx_sr_d = bus.tx_data;
          bit_d   = '0;
          half_d  = HALF_LAST;
        end
      end
      S_LOAD: begin
        if (half_q == 8'd0) begin
          state_d = S_LOW;
          half_d  = HALF_LAST;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_LOW: begin
        // MISO has been stable for DIV cycles since the slave's falling-edge shift.
        if (half_q == 8'd0) begin
          state_d = S_HIGH;
          half_d  = HALF_LAST;
          rx_sr_d = {rx_sr_q[N-2:0], rx_bit};
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (half_q == 8'd0) begin
          half_d  = HALF_LAST;
          tx_sr_d = {tx_sr_q[N-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_d == BIT_LAST) begin
            state_d   = S_DONE;
            rx_data_d = rx_sr_q;
          end else begin
            state_d = S_LOW;
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so the pins never glitch.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    load_d = (state_d == S_LOAD);
    sclk_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      load_q    <= load_d;
      sclk_q    <= sclk_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.load    = load_q;
  assign bus.sclk    = sclk_q;
  assign bus.MOSI    = tx_sr_q[N-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two masters (DIV=4 and DIV=1), each wired to a behavioural
// 16-bit shift-register slave, driven by directed and $urandom frames.
module tb_spi_master_ctrl;

  localparam int N  = 16;
  localparam int NU = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clrn_a  [NU];
  logic         start_a [NU];
  logic [N-1:0] tx_a    [NU];
  logic [N-1:0] di_a    [NU];
  logic         busy_a  [NU];
  logic         done_a  [NU];
  logic         load_a  [NU];
  logic         sclk_a  [NU];
  logic         mosi_a  [NU];
  logic [N-1:0] rx_a    [NU];
  logic [N-1:0] sdo_a   [NU];
  logic [N-1:0] srx_a   [NU];

  logic [N-1:0] prev_tx [NU];
  bit           prev_ok [NU];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < NU; gi++) begin : g_unit
    localparam int D = (gi == 0) ? 4 : 1;

    spi_master_ctrl_if #(.N(N)) bus ();

    logic [N-1:0] di_lat = '0;
    logic [N-1:0] rx_sr  = '0;
    logic [N-1:0] do_reg = '0;
    int           falls  = N;

    assign bus.start   = start_a[gi];
    assign bus.tx_data = tx_a[gi];
    assign bus.MISO    = (falls < N) ? di_lat[N-1-falls] : 1'b0;
    assign busy_a[gi]  = bus.busy;
    assign done_a[gi]  = bus.done;
    assign load_a[gi]  = bus.load;
    assign sclk_a[gi]  = bus.sclk;
    assign mosi_a[gi]  = bus.MOSI;
    assign rx_a[gi]    = bus.rx_data;
    assign sdo_a[gi]   = do_reg;
    assign srx_a[gi]   = rx_sr;

    spi_master_ctrl #(.N(N), .DIV(D)) u_dut (
      .clk  (clk),
      .clrn (clrn_a[gi]),
      .bus  (bus)
    );

    // Slave: load copies DI and publishes the last received word; shifts out on sclk fall.
    always @(posedge clk) begin
      if (bus.load) begin
        di_lat <= di_a[gi];
        do_reg <= rx_sr;
      end
    end

    always @(posedge bus.load or negedge bus.sclk) begin
      if (bus.load) falls <= 0;
      else          falls <= falls + 1;
    end

    always @(posedge bus.sclk) begin
      rx_sr <= {rx_sr[N-2:0], bus.MOSI};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame on unit u. poke_at>0 pulses start mid-frame; abort_at>0 pulls clrn low there.
  task automatic run_frame(input int u, input logic [N-1:0] tx, input logic [N-1:0] di,
                           input int poke_at, input int abort_at);
    int           d, exp_done, done_at, ndone, rises, loads, viol;
    logic         ps, pm, pl;
    logic [N-1:0] rx_before, exp_rx;
    d        = (u == 0) ? 4 : 1;
    exp_done = d + 2 * d * N + 1;
`ifdef SPI_MASTER_LOOPBACK_EN
    exp_rx = tx;
`else
    exp_rx = di;
`endif
    @(negedge clk);
    tx_a[u]    = tx;
    di_a[u]    = di;
    start_a[u] = 1'b1;
    ps = sclk_a[u];
    pm = mosi_a[u];
    pl = load_a[u];
    rx_before = rx_a[u];
    done_at = -1; ndone = 0; rises = 0; loads = 0; viol = 0;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      start_a[u] = (c == poke_at);
      if (c == poke_at) tx_a[u] = ~tx;
      if (c == abort_at) begin
        clrn_a[u] = 1'b0;
        #1;
        chk("abort_sclk", 32'(sclk_a[u]), 32'd0);
        chk("abort_load", 32'(load_a[u]), 32'd0);
        chk("abort_mosi", 32'(mosi_a[u]), 32'd0);
        chk("abort_busy", 32'(busy_a[u]), 32'd0);
        chk("abort_done", 32'(done_a[u]), 32'd0);
        chk("abort_rx",   32'(rx_a[u]),   32'(rx_before));
        $display("frame u=%0d tx=%h aborted at cycle %0d", u, tx, c);
        @(negedge clk);
        clrn_a[u]  = 1'b1;
        prev_ok[u] = 1'b0;
        return;
      end
      if (sclk_a[u] && !ps) rises++;
      if (load_a[u]) loads++;
      if (mosi_a[u] !== pm && !(ps && !sclk_a[u]) && !(load_a[u] && !pl)) viol++;
      if (done_a[u]) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          chk("rx_data", 32'(rx_a[u]), 32'(exp_rx));
          chk("slave_rx", 32'(srx_a[u]), 32'(tx));
        end
      end
      if (c == d + 1 && prev_ok[u]) chk("slave_do", 32'(sdo_a[u]), 32'(prev_tx[u]));
      if (c == exp_done - 1) chk("rx_hold", 32'(rx_a[u]), 32'(rx_before));
      if (c == exp_done)     chk("busy_at_done", 32'(busy_a[u]), 32'd1);
      if (c == exp_done + 1) chk("busy_drop", 32'(busy_a[u]), 32'd0);
      ps = sclk_a[u];
      pm = mosi_a[u];
      pl = load_a[u];
    end
    chk("done_cycle",  32'(done_at), 32'(exp_done));
    chk("done_count",  32'(ndone),   32'd1);
    chk("sclk_rises",  32'(rises),   32'(N));
    chk("load_cycles", 32'(loads),   32'(d));
    chk("mosi_stable", 32'(viol),    32'd0);
    $display("frame u=%0d tx=%h di=%h rx=%h done@%0d", u, tx, di, rx_a[u], done_at);
    prev_tx[u] = tx;
    prev_ok[u] = 1'b1;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      clrn_a[u]  = 1'b0;
      start_a[u] = 1'b0;
      tx_a[u]    = '0;
      di_a[u]    = '0;
      prev_tx[u] = '0;
      prev_ok[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("rst_busy", 32'(busy_a[u]), 32'd0);
      chk("rst_done", 32'(done_a[u]), 32'd0);
      chk("rst_rx",   32'(rx_a[u]),   32'd0);
      chk("rst_load", 32'(load_a[u]), 32'd0);
      chk("rst_sclk", 32'(sclk_a[u]), 32'd0);
      chk("rst_mosi", 32'(mosi_a[u]), 32'd0);
    end
    for (int u = 0; u < NU; u++) clrn_a[u] = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 16'h3C3C, 16'h7777, 0, 70);
    run_frame(0, 16'hA5C3, 16'h1234, 0, 0);
    run_frame(0, 16'h0F0F, 16'($urandom), 0, 0);
    run_frame(0, 16'($urandom), 16'($urandom), 50, 0);
    run_frame(1, 16'hFFFF, 16'h8001, 0, 0);
    run_frame(0, 16'h5AA5, 16'h0000, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int u, poke;
      u    = int'($urandom_range(0, 1));
      poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0;
      run_frame(u, 16'($urandom), 16'($urandom), poke, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
